// File: rtl/display_arbiter.sv
// display_arbiter: chooses which view (timer or alarm) drives the shared VGA
// output. Alarm ringing beats timer expiry, which beats the user's mode button.
// View changes are deferred to a frame boundary and followed by one blanked frame.
module display_arbiter #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int HOLD_FRAMES      = 300,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       alarm_ring,
  input  logic       timer_done,
  input  logic       v_sync_in,
  output logic       sel,
  output logic       user_mode,
  output logic       blank,
  output logic       forced,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    USER       = 2'd0,
    ALARM_OVR  = 2'd1,
    TIMER_HOLD = 2'd2
  } state_t;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_t          st;
  logic            btn_s1, btn_s2;
  logic            deb, deb_q;
  logic [DW-1:0]   deb_cnt;
  logic            vs1, vs2;
  logic            frame_tick;
  logic [HW-1:0]   hold_cnt;
  logic            target;

  // Synchronize and debounce the button; each accepted press toggles the user view.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb       <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt   <= '0;
      user_mode <= 1'b0;
    end else begin
      btn_s1 <= mode_btn;
      btn_s2 <= btn_s1;
      deb_q  <= deb;
      if (deb && !deb_q)
        user_mode <= ~user_mode;
      if (btn_s2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb     <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Two-stage vsync capture used for frame boundary detection.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      vs1 <= 1'b0;
      vs2 <= 1'b0;
    end else begin
      vs1 <= v_sync_in;
      vs2 <= vs1;
    end
  end

  assign frame_tick = (VSYNC_ACTIVE_LOW != 0) ? (vs2 & ~vs1) : (~vs2 & vs1);

  // View demanded by the currently registered state.
  always_comb begin
    target = 1'b0;
    unique case (st)
      USER:       target = user_mode;
      ALARM_OVR:  target = 1'b0;
      TIMER_HOLD: target = 1'b1;
      default:    target = 1'b0;
    endcase
  end

  // Arbitration FSM plus frame-aligned select and one-frame blanking.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      st       <= USER;
      forced   <= 1'b0;
      hold_cnt <= '0;
      sel      <= 1'b0;
      blank    <= 1'b0;
    end else begin
      if (frame_tick) begin
        if (sel != target) begin
          sel   <= target;
          blank <= 1'b1;
        end else begin
          blank <= 1'b0;
        end
      end
      unique case (st)
        USER: begin
          if (alarm_ring) begin
            st     <= ALARM_OVR;
            forced <= 1'b1;
          end else if (timer_done) begin
            st       <= TIMER_HOLD;
            forced   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ALARM_OVR: begin
          if (!alarm_ring) begin
            st     <= USER;
            forced <= 1'b0;
          end
        end
        TIMER_HOLD: begin
          if (alarm_ring) begin
            st <= ALARM_OVR;
          end else if (timer_done) begin
            hold_cnt <= '0;
          end else if (frame_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              st     <= USER;
              forced <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          st     <= USER;
          forced <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed sequences, a state table and random
// stimulus, all checked against a frame/priority-level reference model.
module tb_display_arbiter;

  localparam int D = 16;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       alarm = 1'b0;
  logic       tdone = 1'b0;
  logic       vs = 1'b1;
  logic       sel, user_mode, blank, forced;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  display_arbiter #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_FRAMES     (H),
    .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk_100MHz(clk),
    .reset     (rst_n),
    .mode_btn  (btn),
    .alarm_ring(alarm),
    .timer_done(tdone),
    .v_sync_in (vs),
    .sel       (sel),
    .user_mode (user_mode),
    .blank     (blank),
    .forced    (forced),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 user, 1 alarm override, 2 timer hold.
  int m_sel, m_user, m_blank, m_mode, m_left, m_deb, m_run, m_pend;
  int bq[$];
  int vq[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq = {0, 0};
    vq = {0, 0};
    m_sel = 0; m_user = 0; m_blank = 0; m_mode = 0;
    m_left = H; m_deb = 0; m_run = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    int tick, synced, want;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick   = (vq[0] == 1 && vq[1] == 0) ? 1 : 0;
    synced = bq[0];
    want   = (m_mode == 0) ? m_user : ((m_mode == 1) ? 0 : 1);
    if (m_pend != 0) m_user = 1 - m_user;
    m_pend = 0;
    if (synced != m_deb) begin
      m_run++;
      if (m_run == D) begin
        m_deb = synced;
        m_run = 0;
        if (synced == 1) m_pend = 1;
      end
    end else begin
      m_run = 0;
    end
    if (tick == 1) begin
      if (m_sel != want) begin
        m_sel = want;
        m_blank = 1;
      end else begin
        m_blank = 0;
      end
    end
    if (m_mode == 0) begin
      if (alarm) m_mode = 1;
      else if (tdone) begin
        m_mode = 2;
        m_left = H;
      end
    end else if (m_mode == 1) begin
      if (!alarm) m_mode = 0;
    end else begin
      if (alarm) m_mode = 1;
      else if (tdone) m_left = H;
      else if (tick == 1) begin
        if (m_left == 1) m_mode = 0;
        else m_left--;
      end
    end
    void'(bq.pop_front());
    bq.push_back(int'(btn));
    void'(vq.pop_front());
    vq.push_back(int'(vs));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_sel", int'(sel), m_sel);
    chk("m_user_mode", int'(user_mode), m_user);
    chk("m_blank", int'(blank), m_blank);
    chk("m_forced", int'(forced), (m_mode != 0) ? 1 : 0);
    chk("m_state", int'(state), m_mode);
  endtask

  task automatic frame();
    vs = 1'b0;
    step();
    step();
    vs = 1'b1;
    repeat (10) step();
  endtask

  typedef struct {
    logic       al;
    logic       td;
    logic [1:0] st;
    logic       fr;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int n;
    int fc;
    model_reset();
    tbl[0] = '{1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'd1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 2'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 2'd2, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 2'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 1'b0};

    // Reset and idle frames
    repeat (5) step();
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("idle_sel", int'(sel), 0);
      chk("idle_blank", int'(blank), 0);
      chk("idle_state", int'(state), 0);
    end

    // Clean press
    btn = 1'b1;
    n = 0;
    while (user_mode == 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk("press_latency", n, 19);
    step();
    btn = 1'b0;
    repeat (20) step();
    chk("press_sel_waits", int'(sel), 0);
    vs = 1'b0;
    step();
    chk("tick_not_yet", int'(sel), 0);
    step();
    chk("switch_sel", int'(sel), 1);
    chk("switch_blank", int'(blank), 1);
    vs = 1'b1;
    repeat (10) step();
    frame();
    chk("unblank", int'(blank), 0);
    chk("keep_sel", int'(sel), 1);

    // Bouncing button
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (5) step();
    end
    btn = 1'b0;
    repeat (20) step();
    frame();
    chk("bounce_user", int'(user_mode), 1);
    chk("bounce_sel", int'(sel), 1);

    // Alarm override
    repeat (4) step();
    alarm = 1'b1;
    step();
    chk("alarm_state", int'(state), 1);
    chk("alarm_forced", int'(forced), 1);
    frame();
    chk("alarm_sel", int'(sel), 0);
    chk("alarm_blank", int'(blank), 1);
    alarm = 1'b0;
    step();
    chk("alarm_off_state", int'(state), 0);
    frame();
    chk("alarm_back_sel", int'(sel), 1);
    frame();

    // Timer hold
    btn = 1'b1;
    repeat (25) step();
    btn = 1'b0;
    repeat (20) step();
    chk("user_back_0", int'(user_mode), 0);
    frame();
    frame();
    chk("pre_hold_sel", int'(sel), 0);
    tdone = 1'b1;
    step();
    tdone = 1'b0;
    chk("hold_state", int'(state), 2);
    frame();
    chk("hold_sel_t1", int'(sel), 1);
    frame();
    chk("hold_state_t2", int'(state), 2);
    frame();
    chk("hold_exit_t3", int'(state), 0);
    chk("hold_sel_t3", int'(sel), 1);
    frame();
    chk("hold_sel_t4", int'(sel), 0);
    frame();
    tdone = 1'b1;
    step();
    tdone = 1'b0;
    frame();
    tdone = 1'b1;
    step();
    tdone = 1'b0;
    frame();
    frame();
    chk("restart_hold", int'(state), 2);
    frame();
    chk("restart_exit", int'(state), 0);
    frame();
    frame();

    // Priority table (no frame ticks)
    for (int i = 0; i < 8; i++) begin
      alarm = tbl[i].al;
      tdone = tbl[i].td;
      step();
      chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("tbl%0d_forced", i), int'(forced), int'(tbl[i].fr));
      chk($sformatf("tbl%0d_sel", i), int'(sel), 0);
    end
    alarm = 1'b0;
    tdone = 1'b0;

    // Reset during timer hold
    tdone = 1'b1;
    step();
    tdone = 1'b0;
    frame();
    chk("pre_rst_state", int'(state), 2);
    chk("pre_rst_sel", int'(sel), 1);
    rst_n = 1'b0;
    step();
    chk("rst_sel", int'(sel), 0);
    chk("rst_blank", int'(blank), 0);
    chk("rst_forced", int'(forced), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_user", int'(user_mode), 0);
    rst_n = 1'b1;
    step();

    // Random traffic
    fc = 0;
    for (int i = 0; i < 4000; i++) begin
      vs = ((fc % 14) < 2) ? 1'b0 : 1'b1;
      fc++;
      if ($urandom_range(0, 29) == 0) btn = ~btn;
      if ($urandom_range(0, 149) == 0) alarm = ~alarm;
      tdone = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
